// File: rtl/wishbone_bus_master_if.sv
// ============================================================================
//  Module   : wishbone_bus_master_if
//  Purpose  : Wishbone classic bus bundle between the bus master and a slave.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wishbone_bus_master_if #(
    parameter int DW = 32,
    parameter int SW = 4
);
    logic [DW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          we;
    logic [SW-1:0] sel;
    logic          stb;
    logic          cyc;
    logic          ack;

    modport master (
        output adr, dat_w, we, sel, stb, cyc,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, we, sel, stb, cyc,
        output dat_r, ack
    );
endinterface

`default_nettype wire

// File: rtl/wishbone_bus_master.sv
// ============================================================================
//  Module   : wishbone_bus_master
//  Purpose  : CPU memory port to Wishbone classic single transfers, with
//             pipeline stall, flush handling and a hung-transfer timeout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wishbone_bus_master #(
    parameter int DW      = 32,
    parameter int SW      = 4,
    parameter int TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          cpu_ce_i,
    input  wire logic [DW-1:0] cpu_addr_i,
    input  wire logic [DW-1:0] cpu_data_i,
    input  wire logic          cpu_we_i,
    input  wire logic [SW-1:0] cpu_sel_i,
    output logic      [DW-1:0] cpu_data_o,
    input  wire logic [5:0]    stall_i,
    input  wire logic          flush_i,
    output logic               stallreq_o,
    output logic               bus_err_o,
    wishbone_bus_master_if.master wb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    state_t        r_state,  w_state;
    logic [DW-1:0] r_adr,    w_adr;
    logic [DW-1:0] r_dat,    w_dat;
    logic          r_we,     w_we;
    logic [SW-1:0] r_sel,    w_sel;
    logic          r_active, w_active;
    logic [DW-1:0] r_rd_buf, w_rd_buf;
    logic [7:0]    r_cnt,    w_cnt;
    logic          r_bus_err, w_bus_err;
    logic          w_drop;
    logic          w_stalled;

    assign w_stalled = (stall_i != 6'd0);

    always_comb begin
        w_state    = r_state;
        w_adr      = r_adr;
        w_dat      = r_dat;
        w_we       = r_we;
        w_sel      = r_sel;
        w_active   = r_active;
        w_rd_buf   = r_rd_buf;
        w_cnt      = r_cnt;
        w_bus_err  = 1'b0;
        w_drop     = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = '0;

        case (r_state)
            ST_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    w_adr      = cpu_addr_i;
                    w_dat      = cpu_data_i;
                    w_we       = cpu_we_i;
                    w_sel      = cpu_sel_i;
                    w_active   = 1'b1;
                    w_cnt      = 8'd0;
                    w_state    = ST_BUSY;
                    stallreq_o = 1'b1;
                end
            end
            ST_BUSY: begin
                // Flush takes priority over a coincident ack: the data is discarded.
                if (flush_i) begin
                    w_drop   = 1'b1;
                    w_rd_buf = '0;
                    w_state  = ST_IDLE;
                end else if (wb.ack) begin
                    w_drop = 1'b1;
                    if (!r_we) begin
                        w_rd_buf   = wb.dat_r;
                        cpu_data_o = wb.dat_r;
                    end
                    w_state = w_stalled ? ST_WAIT : ST_IDLE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_drop    = 1'b1;
                    w_rd_buf  = '0;
                    w_bus_err = 1'b1;
                    w_state   = ST_IDLE;
                end else begin
                    w_cnt      = r_cnt + 8'd1;
                    stallreq_o = 1'b1;
                end
            end
            ST_WAIT: begin
                cpu_data_o = r_rd_buf;
                if (flush_i) begin
                    w_rd_buf = '0;
                    w_state  = ST_IDLE;
                end else if (!w_stalled) begin
                    w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase

        if (w_drop) begin
            w_active = 1'b0;
            w_adr    = '0;
            w_dat    = '0;
            w_we     = 1'b0;
            w_sel    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_adr     <= '0;
            r_dat     <= '0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_active  <= 1'b0;
            r_rd_buf  <= '0;
            r_cnt     <= 8'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_adr     <= w_adr;
            r_dat     <= w_dat;
            r_we      <= w_we;
            r_sel     <= w_sel;
            r_active  <= w_active;
            r_rd_buf  <= w_rd_buf;
            r_cnt     <= w_cnt;
            r_bus_err <= w_bus_err;
        end
    end

    // stb and cyc always move together for single transfers.
    assign wb.adr    = r_adr;
    assign wb.dat_w  = r_dat;
    assign wb.we     = r_we;
    assign wb.sel    = r_sel;
    assign wb.stb    = r_active;
    assign wb.cyc    = r_active;
    assign bus_err_o = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_wishbone_bus_master.sv
// ============================================================================
//  Module   : tb_wishbone_bus_master
//  Purpose  : Transaction-level self-checking bench for wishbone_bus_master.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wishbone_bus_master;

    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 8;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          ce       = 1'b0;
    logic [DW-1:0] addr_in  = '0;
    logic [DW-1:0] wdat_in  = '0;
    logic          we_in    = 1'b0;
    logic [SW-1:0] sel_in   = '0;
    logic [5:0]    stall    = '0;
    logic          flush    = 1'b0;
    logic [DW-1:0] cpu_data;
    logic          stallreq;
    logic          bus_err;

    wishbone_bus_master_if #(.DW(DW), .SW(SW)) wb ();

    wishbone_bus_master #(.DW(DW), .SW(SW), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_ce_i   (ce),
        .cpu_addr_i (addr_in),
        .cpu_data_i (wdat_in),
        .cpu_we_i   (we_in),
        .cpu_sel_i  (sel_in),
        .cpu_data_o (cpu_data),
        .stall_i    (stall),
        .flush_i    (flush),
        .stallreq_o (stallreq),
        .bus_err_o  (bus_err),
        .wb         (wb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    // Value the CPU would see from the read buffer while parked in the stall wait.
    logic [DW-1:0] m_rd = '0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_bus(input string tag, input bit exp_err);
        check_val({tag, "_bus"}, {wb.stb, wb.cyc, wb.we, wb.sel, wb.adr, wb.dat_w}, 128'd0);
        check_val({tag, "_err"}, 128'(bus_err), 128'(exp_err));
    endtask

    task automatic run_txn(input bit we, input logic [DW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input int ack_at, input int flush_at,
                           input bit stall_on_ack, input int n_wait, input bit wait_flush);
        int            k;
        int            kind;
        logic [DW-1:0] rdata;
        ce = 1'b1; we_in = we; addr_in = a; wdat_in = d; sel_in = s;
        flush = 1'b0; wb.ack = 1'b0; stall = 6'($urandom);
        #1;
        check_val("req_stallreq", 128'(stallreq), 128'd1);
        check_val("req_data", 128'(cpu_data), 128'd0);
        tick();
        ce = 1'b0; addr_in = $urandom; wdat_in = $urandom; we_in = 1'($urandom); sel_in = 4'($urandom);
        k = 0;
        kind = 0;
        while (kind == 0) begin
            check_val("bus_hold", {wb.stb, wb.cyc, wb.we, wb.sel, wb.adr, wb.dat_w},
                      128'({1'b1, 1'b1, we, s, a, d}));
            rdata    = $urandom;
            wb.dat_r = rdata;
            wb.ack   = (k == ack_at);
            flush    = (k == flush_at);
            stall    = wb.ack ? (stall_on_ack ? 6'($urandom_range(1, 63)) : 6'd0) : 6'($urandom);
            #1;
            if (flush) begin
                check_val("flush_stallreq", 128'(stallreq), 128'd0);
                check_val("flush_data", 128'(cpu_data), 128'd0);
                m_rd = '0;
                kind = 2;
            end else if (wb.ack) begin
                check_val("ack_stallreq", 128'(stallreq), 128'd0);
                check_val("ack_data", 128'(cpu_data), we ? 128'd0 : 128'(rdata));
                if (!we) m_rd = rdata;
                kind = 1;
            end else if (k == TMO - 1) begin
                check_val("tmo_stallreq", 128'(stallreq), 128'd0);
                check_val("tmo_data", 128'(cpu_data), 128'd0);
                m_rd = '0;
                kind = 3;
            end else begin
                check_val("busy_stallreq", 128'(stallreq), 128'd1);
                check_val("busy_data", 128'(cpu_data), 128'd0);
            end
            tick();
            k++;
        end
        wb.ack = 1'b0;
        flush  = 1'b0;
        check_idle_bus("end", kind == 3);

        if (kind == 1 && stall_on_ack) begin
            for (int i = 0; i < n_wait; i++) begin
                stall  = 6'($urandom_range(1, 63));
                wb.ack = 1'($urandom);
                #1;
                check_val("wait_stallreq", 128'(stallreq), 128'd0);
                check_val("wait_data", 128'(cpu_data), 128'(m_rd));
                tick();
            end
            stall  = wait_flush ? 6'($urandom_range(1, 63)) : 6'd0;
            flush  = wait_flush;
            wb.ack = 1'($urandom);
            #1;
            check_val("release_stallreq", 128'(stallreq), 128'd0);
            check_val("release_data", 128'(cpu_data), 128'(m_rd));
            tick();
            if (wait_flush) m_rd = '0;
            flush = 1'b0;
        end

        // One IDLE cycle: stray ack ignored, bus stays down, error pulse gone.
        stall  = 6'($urandom);
        wb.ack = 1'($urandom);
        #1;
        check_val("idle_stallreq", 128'(stallreq), 128'd0);
        check_val("idle_data", 128'(cpu_data), 128'd0);
        tick();
        wb.ack = 1'b0;
        check_idle_bus("idle", 1'b0);
    endtask

    initial begin
        wb.ack   = 1'b0;
        wb.dat_r = '0;
        repeat (3) tick();
        check_idle_bus("reset", 1'b0);
        check_val("reset_stallreq", 128'(stallreq), 128'd0);
        rst_n = 1'b1;
        tick();

        run_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, -1, 1'b0, 0, 1'b0);
        run_txn(1'b1, 32'h0000_1004, 32'h1234_5678, 4'b0011, 1, -1, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1, -1, 1'b1, 2, 1'b0);
        run_txn(1'b0, 32'h0000_0030, 32'h0, 4'hF, 1, 1, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, -1, -1, 1'b0, 0, 1'b0);

        // Reset while BUSY, then a late ack that must be ignored.
        ce = 1'b1; we_in = 1'b1; addr_in = 32'h0000_0100; wdat_in = 32'hCAFE_F00D; sel_in = 4'hF;
        tick();
        ce = 1'b0;
        check_val("rst_busy_stb", 128'(wb.stb), 128'd1);
        rst_n = 1'b0;
        tick();
        check_idle_bus("rst_mid", 1'b0);
        rst_n    = 1'b1;
        wb.ack   = 1'b1;
        wb.dat_r = 32'h5555_AAAA;
        #1;
        check_val("late_ack_stallreq", 128'(stallreq), 128'd0);
        check_val("late_ack_data", 128'(cpu_data), 128'd0);
        tick();
        wb.ack = 1'b0;
        check_idle_bus("late_ack", 1'b0);
        m_rd = '0;
        // A stalled write exposes the read buffer, which reset must have cleared.
        run_txn(1'b1, 32'h0000_0200, 32'h0BAD_0BAD, 4'hF, 0, -1, 1'b1, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, TMO + 1)),
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1,
                    1'($urandom), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
